// File: rtl/max3_window_loader.sv
// Three-sample window loader feeding a max-of-three stage; sliding or block windows.
// Optional MAX3_WINDOW_CNT_EN adds a 16-bit count of completed window handshakes.
module max3_window_loader #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] c,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MAX3_WINDOW_CNT_EN
    ,
    output logic [15:0]             win_count
`endif
);

    localparam logic [2:0] StEmpty = 3'd0;
    localparam logic [2:0] StOne   = 3'd1;
    localparam logic [2:0] StTwo   = 3'd2;
    localparam logic [2:0] StFull  = 3'd3;
    localparam logic [2:0] StHeld  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    mode_q, mode_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic                    accept, handshake;

    assign out_valid = (state_q == StFull);
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // rst_n gates in_ready so nothing is offered upstream while reset is held.
    always_comb begin
        in_ready = 1'b1;
        if (!rst_n || flush) begin
            in_ready = 1'b0;
        end else if (state_q == StFull) begin
            in_ready = mode_q ? 1'b0 : out_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        if (accept) begin
            a_d = b_q;
            b_d = c_q;
            c_d = in_data;
        end
        case (state_q)
            StEmpty: if (accept) begin
                state_d = StOne;
                mode_d  = mode;
            end
            StOne:   if (accept) state_d = StTwo;
            StTwo:   if (accept) state_d = StFull;
            StFull:  if (handshake) begin
                if (mode_q)      state_d = StEmpty;
                else if (accept) state_d = StFull;
                else             state_d = StHeld;
            end
            StHeld:  if (accept) state_d = StFull;
            default: state_d = StEmpty;
        endcase
        // Flush wins over any handshake or accept in the same cycle.
        if (flush) begin
            state_d = StEmpty;
            a_d     = '0;
            b_d     = '0;
            c_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

`ifdef MAX3_WINDOW_CNT_EN
    logic [15:0] win_count_q, win_count_d;

    always_comb begin
        win_count_d = win_count_q;
        if (flush)          win_count_d = 16'd0;
        else if (handshake) win_count_d = win_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_count_q <= 16'd0;
        else        win_count_q <= win_count_d;
    end

    assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_max3_window_loader.sv
// Scoreboard bench for max3_window_loader: directed scenarios plus random traffic.
// Builds with or without MAX3_WINDOW_CNT_EN.
module tb_max3_window_loader;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [15:0] c;
    } win_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic               flush;
    logic signed [15:0] a, b, c;
    logic               out_valid;
    logic               out_ready;
`ifdef MAX3_WINDOW_CNT_EN
    logic [15:0]        win_count;
`endif

    int errors = 0;
    int checks = 0;

    win_t               exp_q[$];
    logic signed [15:0] hist[$];
    logic               mode_m = 1'b0;
    logic [15:0]        cnt_m = 16'd0;

    max3_window_loader #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MAX3_WINDOW_CNT_EN
        ,
        .win_count (win_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor and reference model: windows are the last three samples since the
    // window buffer last emptied; block mode restarts after every third sample.
    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        logic hs;
        win_t w;
        int   n;
        if (!rst_n) begin
            chk("reset_in_ready", int'(in_ready), 0);
            chk("reset_out_valid", int'(out_valid), 0);
            exp_q.delete();
            hist.delete();
            cnt_m = 16'd0;
        end else begin
            if (flush)                exp_rdy = 1'b0;
            else if (exp_q.size() == 0) exp_rdy = 1'b1;
            else                      exp_rdy = mode_m ? 1'b0 : out_ready;
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("win_a", int'(a), int'(exp_q[0].a));
                chk("win_b", int'(b), int'(exp_q[0].b));
                chk("win_c", int'(c), int'(exp_q[0].c));
            end
`ifdef MAX3_WINDOW_CNT_EN
            chk("win_count", int'(win_count), int'(cnt_m));
`endif
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready && !flush;
            if (flush) begin
                exp_q.delete();
                hist.delete();
                cnt_m = 16'd0;
            end else begin
                if (hs && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    cnt_m = cnt_m + 16'd1;
                end
                if (acc) begin
                    if (hist.size() == 0) mode_m = mode;
                    hist.push_back(in_data);
                    n = hist.size();
                    if (n >= 3) begin
                        w.a = hist[n-3];
                        w.b = hist[n-2];
                        w.c = hist[n-1];
                        exp_q.push_back(w);
                        if (mode_m) hist.delete();
                        else        void'(hist.pop_front());
                    end
                end
            end
        end
    end

    // All driver tasks start and finish 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_a", int'(a), 0);
        chk("flush_b", int'(b), 0);
        chk("flush_c", int'(c), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", int'(a), 0);
        chk("reset_out_valid_pre", int'(out_valid), 0);
        rst_n = 1'b1;
        idle(1);

        // Sliding windows
        mode = 1'b0;
        send(16'sd5);
        send(-16'sd3);
        send(16'sd7);
        send(16'sd2);
        idle(3);
        do_flush();

        // Block windows
        mode = 1'b1;
        for (int i = 1; i <= 6; i++) send(16'(i));
        idle(3);

        // Backpressure with a held window
        mode      = 1'b0;
        out_ready = 1'b0;
        send(16'sd10);
        send(16'sd11);
        send(16'sd12);
        fork
            send(16'sd9);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Flush of a partial window, then extreme values
        do_flush();
        send(16'sd100);
        send(16'sd101);
        do_flush();
        send(-16'sd32768);
        send(16'sd32767);
        send(16'sd0);
        idle(1);

        // Now in HELD: reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", int'(out_valid), 0);
        chk("areset_a", int'(a), 0);
        chk("areset_b", int'(b), 0);
        chk("areset_c", int'(c), 0);
        chk("areset_in_ready", int'(in_ready), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            idle(1);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

`ifdef MAX3_WINDOW_CNT_EN
        do_flush();
        mode = 1'b0;
        for (int i = 0; i < 65539; i++) send(16'($urandom));
        idle(3);
        @(negedge clk);
        chk("count_wrap", int'(win_count), 1);
        @(posedge clk);
        #1;
        do_flush();
        chk("count_flush", int'(win_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max3_window_loader.md
MAX3_WINDOW_LOADER -- requirements
Module: max3_window_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the sample width in bits; all data is signed two's complement.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  in  WIDTH signed  the incoming sample.
REQ-005 SHALL have port in_valid  in  1  in_data holds a sample.
REQ-006 SHALL have port in_ready  out  1  the block accepts in_data this cycle.
REQ-007 SHALL have port mode  in  1  window mode: 0 = sliding (overlapping windows), 1 = block (disjoint windows).
REQ-008 SHALL have port flush  in  1  synchronous discard of the partial or held window.
REQ-009 SHALL have ports a, b, c  out  WIDTH signed each  the window: a = oldest, b = middle, c = newest; these drive the downstream max-of-three stage.
REQ-010 SHALL have port out_valid  out  1  a, b and c hold an unconsumed window.
REQ-011 SHALL have port out_ready  in  1  the downstream stage accepts the window.

Function
REQ-012 SHALL accept a sample only when in_valid && in_ready; an accepted sample shifts in: a<=b, b<=c, c<=in_data.
REQ-013 SHALL complete a window handshake only when out_valid && out_ready.
REQ-014 SHALL implement the states EMPTY, ONE, TWO, FULL and HELD; each of the first three states moves to the next on each accept.
REQ-015 SHALL latch mode into mode_q on the accept that leaves EMPTY; mode changes at any other time are ignored until EMPTY is next reached.
REQ-016 SHALL drive out_valid=1 only in FULL; in FULL, a, b and c SHALL stay stable until the handshake.
REQ-017 In sliding mode, in_ready SHALL be !out_valid || out_ready, with behaviour in FULL and HELD as follows:
- FULL with a handshake and an accept in the same cycle: shift, stay in FULL.
- FULL with a handshake only: go to HELD.
- HELD with an accept: shift, go to FULL.
REQ-018 In block mode, in_ready SHALL be !out_valid; a handshake in FULL SHALL go to EMPTY, and the next window is three fresh samples.
REQ-019 SHALL reach out_valid one cycle after the accept that completes a window; there is no combinational path from in_data to a, b or c.
REQ-020 While flush=1, in_ready SHALL be 0; the next state SHALL be EMPTY with out_valid=0 and a, b, c cleared to 0; flush overrides any handshake in that cycle.
REQ-021 SHALL keep in_ready combinational from state, mode_q, flush and out_ready only, never from in_valid.
REQ-022 SHALL NOT drop or duplicate any accepted sample; in sliding mode every accepted sample from the third onward SHALL produce exactly one window.

Reset
REQ-023 When rst_n=0, the block SHALL immediately (asynchronously) set state=EMPTY, mode_q=0, a=b=c=0 and out_valid=0.
REQ-024 During reset, in_ready SHALL be 0; after release, in_ready SHALL be 1 on the first clock edge.
REQ-025 Reset in any state, including mid-window and in HELD, SHALL discard all buffered samples.

Configuration
REQ-026 With macro MAX3_WINDOW_CNT_EN defined, the block SHALL add port win_count  out  16  unsigned count of completed window handshakes.
REQ-027 win_count SHALL wrap from 0xFFFF to 0x0000, and SHALL be cleared by reset and by flush.
REQ-028 Without MAX3_WINDOW_CNT_EN, neither the win_count port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-029 Sliding mode, out_ready=1, inputs 5, -3, 7, 2: windows (5,-3,7) then (-3,7,2); out_valid first rises on the edge after the sample 7 is accepted.
REQ-030 Block mode, out_ready=1, inputs 1..6: windows (1,2,3) then (4,5,6); in_ready=0 while each window is valid.
REQ-031 Backpressure, sliding mode: out_ready=0 for 4 cycles with the window valid: a, b, c stay stable, in_ready=0, no sample is lost; on release the next sample 9 yields (b, c, 9).
REQ-032 Flush after 2 accepted samples, then inputs -32768, 32767, 0: the only window is (-32768, 32767, 0).
REQ-033 rst_n asserted in HELD, between clock edges: out_valid and a, b, c go to 0 at once, state is EMPTY, and no stale window appears after release.
REQ-034 With MAX3_WINDOW_CNT_EN, 65537 handshakes give win_count=1; a flush gives win_count=0.
